// File: rtl/inst_fetch.sv
// inst_fetch: owns the fetch PC, issues in-order word requests to imem,
// buffers returned {pc, inst} pairs and hands them to decode (valid/ready).
// Ports:
//   clk, rst (async, active-high)
//   imem_req/imem_addr/imem_gnt     request channel
//   imem_rvalid/imem_rdata          in-order response channel
//   ID_jmp_vld/ID_jmp_addr          JAL redirect from decode
//   EX_jmp_vld/EX_jmp_addr          branch/JALR/trap redirect (wins over ID)
//   IF_vld/IF_rdy/IF_inst/IF_pc     handshake to decode
module inst_fetch #(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter int          FIFO_DEPTH = 4
) (
    input  logic        clk,
    input  logic        rst,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_gnt,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    input  logic        ID_jmp_vld,
    input  logic [31:0] ID_jmp_addr,
    input  logic        EX_jmp_vld,
    input  logic [31:0] EX_jmp_addr,
    output logic        IF_vld,
    input  logic        IF_rdy,
    output logic [31:0] IF_inst,
    output logic [31:0] IF_pc
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;
    localparam int SW = CW + 1;
    localparam logic [SW-1:0] DEPTH_C = SW'(FIFO_DEPTH);
    localparam logic [31:0]   NOP     = 32'h0000_0013;

    logic [31:0]   fetch_pc_q, fetch_pc_d;
    logic [AW-1:0] pend_wr_q, pend_wr_d;
    logic [AW-1:0] pend_rd_q, pend_rd_d;
    logic [CW-1:0] outstanding_q, outstanding_d;
    logic [CW-1:0] drop_cnt_q, drop_cnt_d;
    logic [AW-1:0] fifo_wr_q, fifo_wr_d;
    logic [AW-1:0] fifo_rd_q, fifo_rd_d;
    logic [CW-1:0] count_q, count_d;

    logic [31:0] pend_pc_q   [FIFO_DEPTH];
    logic [31:0] fifo_pc_q   [FIFO_DEPTH];
    logic [31:0] fifo_inst_q [FIFO_DEPTH];

    logic          redirect;
    logic [31:0]   target;
    logic          pop;
    logic          grant;
    logic          fifo_push;
    logic          fifo_nonempty;
    logic [SW-1:0] credit;

    assign redirect = EX_jmp_vld | ID_jmp_vld;

    always_comb begin
        target = ID_jmp_addr;
        if (EX_jmp_vld) begin
            target = EX_jmp_addr;
        end
        target[1:0] = 2'b00;
    end

    assign fifo_nonempty = (count_q != '0);
    assign IF_vld        = fifo_nonempty & ~redirect;
    assign pop           = IF_vld & IF_rdy;
    assign IF_inst       = fifo_nonempty ? fifo_inst_q[fifo_rd_q] : NOP;
    assign IF_pc         = fifo_nonempty ? fifo_pc_q[fifo_rd_q] : fetch_pc_q;

    // A request is only issued if its word is guaranteed a FIFO slot,
    // counting words already buffered and words still in flight.
    assign credit = {1'b0, outstanding_q} + {1'b0, count_q} - SW'(pop);

    assign imem_req  = ~rst & ~redirect & (credit < DEPTH_C);
    assign imem_addr = fetch_pc_q;
    assign grant     = imem_req & imem_gnt;

    // Words requested before the last redirect are still counted in
    // drop_cnt and must never reach the FIFO.
    assign fifo_push = imem_rvalid & ~redirect & (drop_cnt_q == '0);

    always_comb begin
        fetch_pc_d    = fetch_pc_q;
        pend_wr_d     = pend_wr_q + AW'(grant);
        pend_rd_d     = pend_rd_q + AW'(imem_rvalid);
        outstanding_d = outstanding_q + CW'(grant) - CW'(imem_rvalid);
        drop_cnt_d    = drop_cnt_q;
        fifo_wr_d     = fifo_wr_q;
        fifo_rd_d     = fifo_rd_q;
        count_d       = count_q;

        if (redirect) begin
            fetch_pc_d = target;
            // Everything still in flight after this cycle is wrong-path.
            drop_cnt_d = outstanding_q - CW'(imem_rvalid);
            fifo_rd_d  = fifo_wr_q;
            count_d    = '0;
        end else begin
            if (grant) begin
                fetch_pc_d = fetch_pc_q + 32'd4;
            end
            if (imem_rvalid && drop_cnt_q != '0) begin
                drop_cnt_d = drop_cnt_q - CW'(1);
            end
            fifo_wr_d = fifo_wr_q + AW'(fifo_push);
            fifo_rd_d = fifo_rd_q + AW'(pop);
            count_d   = count_q + CW'(fifo_push) - CW'(pop);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fetch_pc_q    <= RESET_PC;
            pend_wr_q     <= '0;
            pend_rd_q     <= '0;
            outstanding_q <= '0;
            drop_cnt_q    <= '0;
            fifo_wr_q     <= '0;
            fifo_rd_q     <= '0;
            count_q       <= '0;
        end else begin
            fetch_pc_q    <= fetch_pc_d;
            pend_wr_q     <= pend_wr_d;
            pend_rd_q     <= pend_rd_d;
            outstanding_q <= outstanding_d;
            drop_cnt_q    <= drop_cnt_d;
            fifo_wr_q     <= fifo_wr_d;
            fifo_rd_q     <= fifo_rd_d;
            count_q       <= count_d;
        end
    end

    // Storage arrays: contents are qualified by the pointers/counters,
    // so they need no reset.
    always_ff @(posedge clk) begin
        if (grant) begin
            pend_pc_q[pend_wr_q] <= fetch_pc_q;
        end
        if (fifo_push) begin
            fifo_pc_q[fifo_wr_q]   <= pend_pc_q[pend_rd_q];
            fifo_inst_q[fifo_wr_q] <= imem_rdata;
        end
    end

endmodule

// File: tb/tb_inst_fetch.sv
// Randomized bench for inst_fetch: in-order memory model with variable
// latency plus an epoch-based model of the delivered instruction stream.
module tb_inst_fetch;

    localparam logic [31:0] RESET_PC = 32'h0000_0000;
    localparam int          DEPTH    = 4;
    localparam logic [31:0] NOP      = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_gnt = 1'b0;
    logic        imem_rvalid = 1'b0;
    logic [31:0] imem_rdata = '0;
    logic        ID_jmp_vld = 1'b0;
    logic [31:0] ID_jmp_addr = '0;
    logic        EX_jmp_vld = 1'b0;
    logic [31:0] EX_jmp_addr = '0;
    logic        IF_vld;
    logic        IF_rdy = 1'b0;
    logic [31:0] IF_inst;
    logic [31:0] IF_pc;

    inst_fetch #(
        .RESET_PC  (RESET_PC),
        .FIFO_DEPTH(DEPTH)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .imem_req   (imem_req),
        .imem_addr  (imem_addr),
        .imem_gnt   (imem_gnt),
        .imem_rvalid(imem_rvalid),
        .imem_rdata (imem_rdata),
        .ID_jmp_vld (ID_jmp_vld),
        .ID_jmp_addr(ID_jmp_addr),
        .EX_jmp_vld (EX_jmp_vld),
        .EX_jmp_addr(EX_jmp_addr),
        .IF_vld     (IF_vld),
        .IF_rdy     (IF_rdy),
        .IF_inst    (IF_inst),
        .IF_pc      (IF_pc)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] addr;
        int          ep;
        int          due;
    } req_t;

    req_t        mq[$];
    logic [31:0] bufq[$];
    logic [31:0] fa;
    int          epoch;
    int          cyc;
    int          last_due;

    int gnt_pct, rdy_pct, lat_min, lat_max, redir_pct;
    bit          f_set, f_id, f_ex;
    logic [31:0] f_id_a, f_ex_a;

    int errors = 0;
    int checks = 0;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s cyc=%0d got=%h exp=%h", tag, cyc, got, exp);
        end
    endtask

    function automatic logic [31:0] word_of(input logic [31:0] a);
        return {a[15:0], ~a[31:16]} ^ 32'h1357_9bdf;
    endfunction

    task automatic model_reset();
        mq.delete();
        bufq.delete();
        fa       = RESET_PC;
        epoch    = epoch + 1;
        last_due = 0;
    endtask

    task automatic step_body();
        logic        redir, e_vld, e_req, pop, grant;
        logic [31:0] tgt, e_pc, e_inst;
        req_t        r;
        int          due;

        imem_gnt = ($urandom_range(99) < gnt_pct);
        IF_rdy   = ($urandom_range(99) < rdy_pct);
        if (f_set) begin
            ID_jmp_vld  = f_id;
            ID_jmp_addr = f_id_a;
            EX_jmp_vld  = f_ex;
            EX_jmp_addr = f_ex_a;
            f_set       = 1'b0;
        end else begin
            ID_jmp_vld  = ($urandom_range(99) < redir_pct);
            ID_jmp_addr = $urandom;
            EX_jmp_vld  = ($urandom_range(99) < redir_pct);
            EX_jmp_addr = $urandom;
        end
        imem_rvalid = (mq.size() != 0) && (mq[0].due <= cyc);
        imem_rdata  = imem_rvalid ? word_of(mq[0].addr) : $urandom;
        #1;

        assert (!(imem_rvalid && mq.size() == 0))
        else $error("response with nothing outstanding");

        redir = ID_jmp_vld | EX_jmp_vld;
        tgt   = EX_jmp_vld ? EX_jmp_addr : ID_jmp_addr;
        tgt   = tgt & 32'hffff_fffc;
        e_vld = (bufq.size() != 0) && !redir;
        e_pc  = (bufq.size() != 0) ? bufq[0] : fa;
        e_inst = (bufq.size() != 0) ? word_of(bufq[0]) : NOP;
        pop   = e_vld && IF_rdy;
        e_req = !redir &&
                (mq.size() + bufq.size() - int'(pop) < DEPTH);

        check("if_vld", IF_vld, e_vld);
        check("if_pc", IF_pc, e_pc);
        check("if_inst", IF_inst, e_inst);
        check("imem_req", imem_req, e_req);
        check("imem_addr", imem_addr, fa);

        grant = e_req && imem_gnt;
        if (pop) void'(bufq.pop_front());
        if (imem_rvalid) begin
            r = mq.pop_front();
            if (r.ep == epoch && !redir) bufq.push_back(r.addr);
        end
        if (grant) begin
            due = cyc + 1 + int'($urandom_range(lat_max, lat_min));
            if (due < last_due) due = last_due;
            last_due = due;
            mq.push_back('{addr: fa, ep: epoch, due: due});
            fa = fa + 32'd4;
        end
        if (redir) begin
            bufq.delete();
            epoch = epoch + 1;
            fa    = tgt;
        end
        cyc++;
    endtask

    task automatic step();
        @(negedge clk);
        step_body();
    endtask

    task automatic wait_deliver(input string tag, input logic [31:0] pc);
        bit hit = 1'b0;
        for (int i = 0; i < 40 && !hit; i++) begin
            step();
            if (IF_vld && IF_rdy) begin
                hit = 1'b1;
                check(tag, IF_pc, pc);
            end
        end
        if (!hit) check({tag, "_timeout"}, 32'd0, 32'd1);
    endtask

    task automatic force_jmp(input bit id, input logic [31:0] ida,
                             input bit ex, input logic [31:0] exa);
        f_set  = 1'b1;
        f_id   = id;
        f_id_a = ida;
        f_ex   = ex;
        f_ex_a = exa;
    endtask

    task automatic reset_mid();
        #2 rst = 1'b1;
        #1;
        check("rst_vld", IF_vld, 1'b0);
        check("rst_req", imem_req, 1'b0);
        check("rst_pc", IF_pc, RESET_PC);
        check("rst_inst", IF_inst, NOP);
        model_reset();
        imem_gnt    = 1'b0;
        imem_rvalid = 1'b0;
        ID_jmp_vld  = 1'b0;
        EX_jmp_vld  = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        step_body();
        check("post_rst_addr", imem_addr, RESET_PC);
    endtask

    initial begin
        int  stale;
        bit  hit;
        epoch = 0;
        cyc   = 0;
        f_set = 1'b0;
        #1;
        check("init_vld", IF_vld, 1'b0);
        check("init_req", imem_req, 1'b0);
        check("init_pc", IF_pc, RESET_PC);
        check("init_inst", IF_inst, NOP);
        model_reset();

        gnt_pct = 100; rdy_pct = 100;
        lat_min = 0; lat_max = 0; redir_pct = 0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        step_body();
        repeat (20) step();

        rdy_pct = 0;
        repeat (10) step();
        check("stall_req", imem_req, 1'b0);
        rdy_pct = 100;
        repeat (10) step();

        lat_min = 2; lat_max = 2;
        hit = 1'b0;
        for (int i = 0; i < 20 && !hit; i++) begin
            if (mq.size() == 2) hit = 1'b1;
            else step();
        end
        check("two_outst", hit, 1'b1);
        force_jmp(1'b1, 32'h103, 1'b0, 32'h0);
        step();
        step();
        check("jal_addr", imem_addr, 32'h100);
        check("jal_req", imem_req, 1'b1);
        wait_deliver("jal_first_pc", 32'h100);

        force_jmp(1'b1, 32'h200, 1'b1, 32'h400);
        step();
        step();
        check("both_addr", imem_addr, 32'h400);
        wait_deliver("both_first_pc", 32'h400);

        lat_min = 3; lat_max = 3;
        repeat (8) step();
        force_jmp(1'b0, 32'h0, 1'b1, 32'h600);
        step();
        hit = 1'b0;
        for (int i = 0; i < 20 && !hit; i++) begin
            stale = 0;
            foreach (mq[k]) if (mq[k].ep != epoch) stale++;
            if (stale == 2 && mq[0].due <= cyc) hit = 1'b1;
            else step();
        end
        check("drop2_window", hit, 1'b1);
        force_jmp(1'b0, 32'h0, 1'b1, 32'h800);
        step();
        check("ex2_rvalid", imem_rvalid, 1'b1);
        wait_deliver("ex2_first_pc", 32'h800);

        gnt_pct = 70; rdy_pct = 70;
        lat_min = 0; lat_max = 3; redir_pct = 4;
        repeat (3000) step();

        redir_pct = 0; gnt_pct = 100; rdy_pct = 0;
        lat_min = 0; lat_max = 0;
        repeat (4) step();
        repeat (8) step();
        check("full_vld", IF_vld, 1'b1);
        reset_mid();
        rdy_pct = 100;
        repeat (20) step();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
